instr_sequencer: RTL and testbench

Multi-cycle fetch/sequencing unit for the 8-bit non-pipelined processor and the driving end of the control unit's opcode interface. It fetches 8-bit instructions from instruction memory over a req/valid handshake and holds them in an instruction register. It presents the opcode field (ir[7:5]) on output_ctrl_unit_opcode and steps through one-hot stage enables (decode/execute/mem/writeback) that gate the control unit's register_write, memread and memwrite outputs into the datapath. It also tracks the PC, retired-instruction count, halt and fetch-timeout fault.

---
 rtl/instr_sequencer_if.sv | 25 ++
 rtl/instr_sequencer.sv | 153 +++++++++++++++
 tb/tb_instr_sequencer.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_sequencer_if.sv
// Instruction fetch and data-memory completion handshake between the
// sequencer (master) and the memory subsystem (slave).
interface instr_sequencer_if;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic [7:0] imem_rdata;
  logic       imem_valid;
  logic       dmem_done;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_valid,
    input  dmem_done
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_valid,
    output dmem_done
  );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/sequencing unit for the 8-bit non-pipelined processor.
// Fetches instructions over a req/valid handshake, holds them in the IR and
// walks one-hot stage enables (decode/execute/mem/writeback) that gate the
// control unit's datapath strobes. Tracks PC, retired count, halt and a
// fetch-timeout fault. Every output is a register or a decode of state.
module instr_sequencer #(
  parameter logic [7:0]  RESET_PC      = 8'h00,
  parameter int unsigned FETCH_TIMEOUT = 15,
  parameter logic [2:0]  HALT_OPCODE   = 3'b011
) (
  input  logic                     clk,
  input  logic                     reset,
  instr_sequencer_if.master        mem_if,
  input  logic                     start,
  output logic [2:0]               output_ctrl_unit_opcode,
  output logic [4:0]               ir_operands,
  output logic [7:0]               pc,
  output logic                     decode_en,
  output logic                     execute_en,
  output logic                     mem_en,
  output logic                     wb_en,
  output logic                     halted,
  output logic                     fault,
  output logic [15:0]              retired_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_WB,
    S_HALTED,
    S_FAULT
  } state_t;

  // Timeout count value at which one more empty FETCH cycle means FAULT.
  localparam logic [7:0] TO_LAST = 8'(FETCH_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [7:0]  ir_q, ir_d;
  logic [7:0]  to_cnt_q, to_cnt_d;
  logic [15:0] retired_q, retired_d;
  logic        retire;

  // Opcodes 110 (load) and 111 (store) go through MEM; bit 5 picks store.
  logic is_mem_op;
  logic is_store;
  assign is_mem_op = (ir_q[7:6] == 2'b11);
  assign is_store  = ir_q[5];

  // State and architectural registers; reset abandons any in-flight instruction.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= 8'h00;
      to_cnt_q  <= 8'h00;
      retired_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      to_cnt_q  <= to_cnt_d;
      retired_q <= retired_d;
    end
  end

  // Next-state and register updates for the fetch/decode/execute/mem/wb walk.
  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    to_cnt_d = to_cnt_q;
    retire   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (mem_if.imem_valid) begin
          // A valid word on the final allowed cycle still wins over the fault.
          ir_d     = mem_if.imem_rdata;
          pc_d     = pc_q + 8'd1;
          to_cnt_d = 8'h00;
          state_d  = S_DECODE;
        end else begin
          to_cnt_d = to_cnt_q + 8'd1;
          if (to_cnt_q == TO_LAST) state_d = S_FAULT;
        end
      end
      S_DECODE: begin
        if (ir_q[7:5] == HALT_OPCODE) begin
          state_d = S_HALTED;
          retire  = 1'b1;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        state_d = is_mem_op ? S_MEM : S_WB;
      end
      S_MEM: begin
        if (mem_if.dmem_done) begin
          if (is_store) begin
            // Stores have nothing to write back; they retire here.
            state_d = S_FETCH;
            retire  = 1'b1;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      default: begin
        // HALTED and FAULT are terminal until reset.
        state_d = state_q;
      end
    endcase
  end

  // Saturating retired-instruction counter.
  always_comb begin
    retired_d = retired_q;
    if (retire && (retired_q != 16'hFFFF)) retired_d = retired_q + 16'd1;
  end

  // Moore outputs: decoded from state so they drop as soon as reset hits.
  assign mem_if.imem_req  = (state_q == S_FETCH);
  assign mem_if.imem_addr = pc_q;

  assign decode_en  = (state_q == S_DECODE);
  assign execute_en = (state_q == S_EXECUTE);
  assign mem_en     = (state_q == S_MEM);
  assign wb_en      = (state_q == S_WB);
  assign halted     = (state_q == S_HALTED);
  assign fault      = (state_q == S_FAULT);

  assign output_ctrl_unit_opcode = ir_q[7:5];
  assign ir_operands             = ir_q[4:0];
  assign pc                      = pc_q;
  assign retired_count           = retired_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed latency table, hand
// sequences for reset/halt/timeout/wrap, and a randomized program checked
// cycle by cycle against an instruction-level reference model.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  opcode;
  logic [4:0]  operands;
  logic [7:0]  pc;
  logic        decode_en, execute_en, mem_en, wb_en;
  logic        halted, fault;
  logic [15:0] retired;

  // Second instance with RESET_PC = FF for the PC wrap case.
  logic        start_w;
  logic [2:0]  opcode_w;
  logic [4:0]  operands_w;
  logic [7:0]  pc_w;
  logic        decode_en_w, execute_en_w, mem_en_w, wb_en_w;
  logic        halted_w, fault_w;
  logic [15:0] retired_w;

  instr_sequencer_if bus ();
  instr_sequencer_if wbus ();

  instr_sequencer dut (
    .clk                     (clk),
    .reset                   (reset),
    .mem_if                  (bus),
    .start                   (start),
    .output_ctrl_unit_opcode (opcode),
    .ir_operands             (operands),
    .pc                      (pc),
    .decode_en               (decode_en),
    .execute_en              (execute_en),
    .mem_en                  (mem_en),
    .wb_en                   (wb_en),
    .halted                  (halted),
    .fault                   (fault),
    .retired_count           (retired)
  );

  instr_sequencer #(.RESET_PC(8'hFF)) dut_wrap (
    .clk                     (clk),
    .reset                   (reset),
    .mem_if                  (wbus),
    .start                   (start_w),
    .output_ctrl_unit_opcode (opcode_w),
    .ir_operands             (operands_w),
    .pc                      (pc_w),
    .decode_en               (decode_en_w),
    .execute_en              (execute_en_w),
    .mem_en                  (mem_en_w),
    .wb_en                   (wb_en_w),
    .halted                  (halted_w),
    .fault                   (fault_w),
    .retired_count           (retired_w)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef enum {T_IDLE, T_F, T_D, T_E, T_M, T_W, T_H, T_X} tstage_t;

  typedef struct {
    logic [7:0] word;
    int         fw;       // fetch wait cycles before valid
    int         mw;       // MEM wait cycles before done
    int         exp_cyc;  // cycles from fetch start to next fetch
    int         exp_mem;  // cycles with mem_en high
    int         exp_wb;   // cycles with wb_en high
  } vec_t;

  // Reference model state (instruction level).
  logic [7:0]  m_pc;
  logic [7:0]  m_ir;
  logic [15:0] m_ret;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic logic [7:0] rw();
    return 8'($urandom);
  endfunction

  task automatic bump();
    if (m_ret != 16'hFFFF) m_ret = m_ret + 16'd1;
  endtask

  // Compare every visible output against the model for the expected stage.
  task automatic check_state(input tstage_t st);
    logic [3:0] exp_en;
    exp_en = 4'b0000;
    case (st)
      T_D: exp_en = 4'b1000;
      T_E: exp_en = 4'b0100;
      T_M: exp_en = 4'b0010;
      T_W: exp_en = 4'b0001;
      default: exp_en = 4'b0000;
    endcase
    check("enables",   {decode_en, execute_en, mem_en, wb_en}, exp_en);
    check("imem_req",  bus.imem_req, st == T_F);
    check("imem_addr", bus.imem_addr, m_pc);
    check("pc",        pc, m_pc);
    check("opcode",    opcode, m_ir[7:5]);
    check("operands",  operands, m_ir[4:0]);
    check("retired",   retired, m_ret);
    check("halted",    halted, st == T_H);
    check("fault",     fault, st == T_X);
  endtask

  // Drive inputs for the coming rising edge, then return at the next falling edge.
  task automatic tick(input logic s, input logic v, input logic [7:0] rd, input logic d);
    start          = s;
    bus.imem_valid = v;
    bus.imem_rdata = rd;
    bus.dmem_done  = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    start          = 1'b0;
    start_w        = 1'b0;
    bus.imem_valid = 1'b0;
    bus.imem_rdata = 8'h00;
    bus.dmem_done  = 1'b0;
    wbus.imem_valid = 1'b0;
    wbus.imem_rdata = 8'h00;
    wbus.dmem_done  = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_pc  = 8'h00;
    m_ir  = 8'h00;
    m_ret = 16'h0000;
  endtask

  // Run one instruction from FETCH to the next FETCH with reactive memory waits.
  task automatic run_vec(input vec_t v, input int idx);
    int         cyc, fcnt, mcnt, mem_c, wb_c;
    bit         left, ok;
    logic [15:0] r0;
    logic [7:0]  p0;
    cyc = 0; fcnt = 0; mcnt = 0; mem_c = 0; wb_c = 0; left = 0; ok = 0;
    r0 = retired;
    p0 = m_pc;
    check($sformatf("vec%0d_addr", idx), bus.imem_addr, p0);
    for (int t = 0; t < 64; t++) begin
      if (left && bus.imem_req) begin
        ok = 1;
        break;
      end
      start          = rb();
      bus.imem_valid = bus.imem_req && (fcnt == v.fw);
      bus.imem_rdata = v.word;
      bus.dmem_done  = mem_en && (mcnt == v.mw);
      if (bus.imem_req) fcnt++;
      else left = 1;
      if (mem_en) begin
        mcnt++;
        mem_c++;
      end
      if (wb_en) wb_c++;
      cyc++;
      @(posedge clk);
      @(negedge clk);
    end
    m_pc = p0 + 8'd1;
    check($sformatf("vec%0d_refetch", idx), ok, 1);
    check($sformatf("vec%0d_cycles", idx), cyc, v.exp_cyc);
    check($sformatf("vec%0d_mem_cycles", idx), mem_c, v.exp_mem);
    check($sformatf("vec%0d_wb_cycles", idx), wb_c, v.exp_wb);
    check($sformatf("vec%0d_pc", idx), pc, m_pc);
    check($sformatf("vec%0d_opcode", idx), opcode, v.word[7:5]);
    check($sformatf("vec%0d_operands", idx), operands, v.word[4:0]);
    check($sformatf("vec%0d_retired", idx), retired, r0 + 16'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs[6];
    logic [7:0] w;
    int         fw, mw, n;
    logic [2:0] op;

    vecs[0] = '{8'h9A, 0, 0, 4, 0, 1};  // ALU, zero wait
    vecs[1] = '{8'hC5, 0, 2, 7, 3, 1};  // load, dmem_done after 2 waits
    vecs[2] = '{8'hE3, 0, 2, 6, 3, 0};  // store, dmem_done after 2 waits
    vecs[3] = '{8'h45, 2, 0, 6, 0, 1};  // ALU, 2 fetch waits
    vecs[4] = '{8'hC0, 1, 0, 6, 1, 1};  // load, 1 fetch wait
    vecs[5] = '{8'hFF, 0, 0, 4, 1, 0};  // store, zero wait

    @(negedge clk);

    // Reset / idle: start held low for 5 cycles.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      check_state(T_IDLE);
      tick(1'b0, rb(), rw(), rb());
    end

    // Directed latency table, starting from PC 00.
    tick(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);
    check("table_retired_total", retired, 16'd6);
    check("table_pc_total", pc, 8'h06);

    // PC wrap on the RESET_PC = FF instance.
    do_reset();
    check("wrap_reset_pc", pc_w, 8'hFF);
    start_w = 1'b1;
    @(posedge clk); @(negedge clk);
    start_w = 1'b0;
    check("wrap_req", wbus.imem_req, 1'b1);
    check("wrap_addr", wbus.imem_addr, 8'hFF);
    wbus.imem_valid = 1'b1;
    wbus.imem_rdata = 8'h9A;
    @(posedge clk); @(negedge clk);
    wbus.imem_valid = 1'b0;
    check("wrap_pc_after", pc_w, 8'h00);
    check("wrap_decode", decode_en_w, 1'b1);
    check("wrap_opcode", opcode_w, 3'b100);

    // Halt: 8'h60 retires through DECODE and parks; start is ignored.
    do_reset();
    tick(1'b1, 1'b0, 8'h00, 1'b0);
    check_state(T_F);
    tick(1'b0, 1'b1, 8'h60, 1'b0);
    m_ir = 8'h60; m_pc = 8'h01;
    check_state(T_D);
    tick(1'b0, rb(), rw(), rb());
    bump();
    for (int i = 0; i < 4; i++) begin
      check_state(T_H);
      tick(1'b1, rb(), rw(), rb());
    end

    // Fetch timeout: no valid ever; fault exactly 15 cycles after FETCH entry.
    do_reset();
    tick(1'b1, 1'b0, 8'h00, 1'b0);
    n = 0;
    while (!fault && n < 40) begin
      tick(1'b0, 1'b0, rw(), rb());
      n++;
    end
    check("timeout_cycles", n, 15);
    for (int i = 0; i < 3; i++) begin
      check_state(T_X);
      tick(1'b1, rb(), rw(), rb());
    end

    // Reset in the middle of a waiting load.
    do_reset();
    tick(1'b1, 1'b0, 8'h00, 1'b0);
    check_state(T_F);
    tick(1'b0, 1'b1, 8'hC5, 1'b0);
    m_ir = 8'hC5; m_pc = 8'h01;
    check_state(T_D);
    tick(1'b0, 1'b0, 8'h00, 1'b0);
    check_state(T_E);
    tick(1'b0, 1'b0, 8'h00, 1'b0);
    check_state(T_M);
    tick(1'b0, 1'b0, 8'h00, 1'b0);
    check_state(T_M);
    #2 reset = 1'b1;
    #1;
    check("midrst_mem_en", mem_en, 1'b0);
    check("midrst_imem_req", bus.imem_req, 1'b0);
    check("midrst_pc", pc, 8'h00);
    check("midrst_retired", retired, 16'd0);
    check("midrst_opcode", opcode, 3'b000);
    @(negedge clk);
    reset = 1'b0;

    // Randomized program against the instruction-level model.
    do_reset();
    check_state(T_IDLE);
    tick(1'b1, rb(), rw(), rb());
    for (int i = 0; i < 80; i++) begin
      fw = $urandom_range(0, 3);
      mw = $urandom_range(0, 3);
      if (i == 79) w = 8'h7F;
      else begin
        w = rw();
        while (w[7:5] == 3'b011) w = rw();
      end
      for (int k = 0; k <= fw; k++) begin
        check_state(T_F);
        tick(rb(), k == fw, (k == fw) ? w : rw(), rb());
      end
      m_ir = w;
      m_pc = m_pc + 8'd1;
      op   = w[7:5];
      check_state(T_D);
      tick(rb(), rb(), rw(), rb());
      if (op == 3'b011) begin
        bump();
        for (int k = 0; k < 3; k++) begin
          check_state(T_H);
          tick(1'b1, rb(), rw(), rb());
        end
        break;
      end
      check_state(T_E);
      tick(rb(), rb(), rw(), rb());
      if (op == 3'b110 || op == 3'b111) begin
        for (int k = 0; k <= mw; k++) begin
          check_state(T_M);
          tick(rb(), rb(), rw(), k == mw);
        end
        if (op == 3'b111) begin
          bump();
          continue;
        end
      end
      check_state(T_W);
      tick(rb(), rb(), rw(), rb());
      bump();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
